uart_tx_feed: RTL and testbench

UART_TX_FEED -- requirements
Module: uart_tx_feed

---
 rtl/uart_tx_feed.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_feed.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feed.sv
// Byte FIFO feeding an 8-bit UART transmitter: 8N1 by default, 8E1 when
// UART_TX_FEED_PARITY_EN is defined.
module uart_tx_feed #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       uart_tx_pin,
   output logic       busy
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_FEED_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]    idx_reg, idx_next;
   logic [7:0]    shift_reg, shift_next;
   logic          tx_reg, tx_next;
`ifdef UART_TX_FEED_PARITY_EN
   logic          parity_reg, parity_next;
`endif

   // FIFO: pointers carry one extra wrap bit so full and empty are distinct
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
   logic          full, empty, push, pop;
   logic [7:0]    head;
   logic          bit_done;

   assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign push     = in_valid && !full;
   // Head is read combinationally so IDLE can pop and start on the same edge
   assign head     = mem[rd_ptr_reg[AW-1:0]];
   assign bit_done = (cnt_reg == CNT_LAST);

   assign in_ready    = !full;
   assign uart_tx_pin = tx_reg;
   assign busy        = (state_reg != IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr_reg[AW-1:0]] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         idx_reg    <= '0;
         shift_reg  <= '0;
         tx_reg     <= 1'b1;
`ifdef UART_TX_FEED_PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         idx_reg    <= idx_next;
         shift_reg  <= shift_next;
         tx_reg     <= tx_next;
`ifdef UART_TX_FEED_PARITY_EN
         parity_reg <= parity_next;
`endif
      end
   end

   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      shift_next  = shift_reg;
      tx_next     = tx_reg;
      pop         = 1'b0;
`ifdef UART_TX_FEED_PARITY_EN
      parity_next = parity_reg;
`endif
      // Every state change coincides with bit_done, so the counter restarts at 0
      cnt_next    = bit_done ? '0 : cnt_reg + 1'b1;

      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            tx_next  = 1'b1;
            if (!empty) begin
               pop        = 1'b1;
               shift_next = head;
               idx_next   = '0;
               tx_next    = 1'b0;
               state_next = START;
`ifdef UART_TX_FEED_PARITY_EN
               parity_next = ^head;
`endif
            end
         end
         START: begin
            if (bit_done) begin
               state_next = DATA;
               tx_next    = shift_reg[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               if (idx_reg == 3'd7) begin
`ifdef UART_TX_FEED_PARITY_EN
                  state_next = PARITY;
                  tx_next    = parity_reg;
`else
                  state_next = STOP;
                  tx_next    = 1'b1;
`endif
               end else begin
                  idx_next   = idx_reg + 3'd1;
                  shift_next = {1'b0, shift_reg[7:1]};
                  tx_next    = shift_reg[1];
               end
            end
         end
`ifdef UART_TX_FEED_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               state_next = STOP;
               tx_next    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_done) begin
               state_next = IDLE;
               tx_next    = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
            tx_next    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_feed.sv
// Directed bench for uart_tx_feed at CLK_FREQ=8, BAUD=1 (8 clocks per bit).
module tb_uart_tx_feed;

   localparam int DIV_TB = 8;
`ifdef UART_TX_FEED_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CYC = NBITS * DIV_TB;
   localparam int PERIOD    = FRAME_CYC + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       uart_tx_pin;
   logic       busy;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   uart_tx_feed #(
      .CLK_FREQ(8),
      .BAUD(1),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .uart_tx_pin(uart_tx_pin),
      .busy(busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected line level j cycles after a frame's start bit begins
   function automatic logic exp_bit(input logic [7:0] b, input int j);
      int slot;
      slot = j / DIV_TB;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
`ifdef UART_TX_FEED_PARITY_EN
      if (slot == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      in_valid = 1'b0;
      tick;
      tick;
      compared++;
      if (uart_tx_pin !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_state got tx=%b busy=%b ready=%b want 1/0/1", uart_tx_pin, busy, in_ready);
      end
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick;
         compared++;
         if (uart_tx_pin !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL idle_line cyc=%0d got tx=%b busy=%b ready=%b want 1/0/1", i, uart_tx_pin, busy, in_ready);
         end
      end
      $display("reset: idle line checked for 50 cycles");
   endtask

   task automatic test_single;
      logic e;
      compared++;
      if (in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL single_ready got %b want 1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = 8'h55;
      tick;
      in_valid = 1'b0;
      compared++;
      if (uart_tx_pin !== 1'b1 || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL single_accept got tx=%b busy=%b want 1/1", uart_tx_pin, busy);
      end
      for (int k = 1; k <= FRAME_CYC; k++) begin
         tick;
         e = exp_bit(8'h55, k - 1);
         compared++;
         if (uart_tx_pin !== e || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL single_line N+%0d got tx=%b busy=%b want %b/1", k, uart_tx_pin, busy, e);
         end
      end
      tick;
      compared++;
      if (busy !== 1'b0 || uart_tx_pin !== 1'b1) begin
         mismatched++;
         $display("FAIL single_done got busy=%b tx=%b want 0/1", busy, uart_tx_pin);
      end
      $display("single: frame 0x55 checked");
   endtask

   task automatic test_back_to_back;
      logic [7:0] seq [6];
      logic       e;
      int         last_t;
      int         s;
      seq[0] = 8'hFF; seq[1] = 8'h01; seq[2] = 8'h02;
      seq[3] = 8'h03; seq[4] = 8'h04; seq[5] = 8'h06;
      last_t = 1 + 5 * PERIOD + FRAME_CYC;
      for (int t = 0; t <= last_t + 20; t++) begin
         in_valid = 1'b0;
         in_data  = 8'h00;
         if (t == 0) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
         end else if (t >= 2 && t <= 5) begin
            in_valid = 1'b1;
            in_data  = 8'(t - 1);
            compared++;
            if (in_ready !== 1'b1) begin
               mismatched++;
               $display("FAIL b2b_fill_ready t=%0d got %b want 1", t, in_ready);
            end
         end else if (t == 6) begin
            in_valid = 1'b1;
            in_data  = 8'h05;
            compared++;
            if (in_ready !== 1'b0) begin
               mismatched++;
               $display("FAIL b2b_full_ready got %b want 0", in_ready);
            end
         end else if (t == 1 + PERIOD) begin
            in_valid = 1'b1;
            in_data  = 8'h06;
            compared++;
            if (in_ready !== 1'b0) begin
               mismatched++;
               $display("FAIL full_pop_edge_ready got %b want 0", in_ready);
            end
         end else if (t == 1 + 2 * PERIOD) begin
            in_valid = 1'b1;
            in_data  = 8'h06;
            compared++;
            if (in_ready !== 1'b1) begin
               mismatched++;
               $display("FAIL push_pop_ready_pre got %b want 1", in_ready);
            end
         end
         tick;
         e = 1'b1;
         for (int f = 0; f < 6; f++) begin
            s = 1 + f * PERIOD;
            if (t >= s && t < s + FRAME_CYC) e = exp_bit(seq[f], t - s);
         end
         compared++;
         if (uart_tx_pin !== e || busy !== (t < last_t)) begin
            mismatched++;
            $display("FAIL b2b_line t=%0d got tx=%b busy=%b want %b/%b", t, uart_tx_pin, busy, e, (t < last_t));
         end
         if (t == 6 || t == 1 + PERIOD || t == 1 + 2 * PERIOD) begin
            compared++;
            if (in_ready !== ((t == 6) ? 1'b0 : 1'b1)) begin
               mismatched++;
               $display("FAIL b2b_ready_post t=%0d got %b want %b", t, in_ready, (t != 6));
            end
         end
      end
      in_valid = 1'b0;
      $display("back_to_back: frames FF 01 02 03 04 06 checked, 05 refused");
   endtask

   task automatic test_reset_mid;
      logic e;
      for (int t = 0; t <= 35; t++) begin
         in_valid = 1'b0;
         if (t == 0) begin in_valid = 1'b1; in_data = 8'hA5; end
         if (t == 2) begin in_valid = 1'b1; in_data = 8'h11; end
         if (t == 3) begin in_valid = 1'b1; in_data = 8'h22; end
         if (t == 35) rst = 1'b1;
         tick;
         rst = 1'b0;
         if (t < 35) begin
            e = (t == 0) ? 1'b1 : exp_bit(8'hA5, t - 1);
            compared++;
            if (uart_tx_pin !== e) begin
               mismatched++;
               $display("FAIL abort_pre t=%0d got tx=%b want %b", t, uart_tx_pin, e);
            end
         end else begin
            compared++;
            if (uart_tx_pin !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
               mismatched++;
               $display("FAIL abort_reset got tx=%b busy=%b ready=%b want 1/0/1", uart_tx_pin, busy, in_ready);
            end
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick;
         compared++;
         if (uart_tx_pin !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_quiet cyc=%0d got tx=%b busy=%b want 1/0", i, uart_tx_pin, busy);
         end
      end
      $display("reset_mid: 0xA5 aborted in bit 3, queue discarded");
   endtask

`ifdef UART_TX_FEED_PARITY_EN
   task automatic test_parity;
      logic [7:0] bytes [2];
      logic       par [2];
      logic       e;
      bytes[0] = 8'h07; par[0] = 1'b1;
      bytes[1] = 8'h03; par[1] = 1'b0;
      for (int n = 0; n < 2; n++) begin
         in_valid = 1'b1;
         in_data  = bytes[n];
         tick;
         in_valid = 1'b0;
         for (int k = 1; k <= FRAME_CYC; k++) begin
            tick;
            e = exp_bit(bytes[n], k - 1);
            if (k - 1 >= 72 && k - 1 < 80) e = par[n];
            compared++;
            if (uart_tx_pin !== e) begin
               mismatched++;
               $display("FAIL parity_line byte=%h N+%0d got %b want %b", bytes[n], k, uart_tx_pin, e);
            end
         end
         tick;
         $display("parity: frame %h checked with parity %b", bytes[n], par[n]);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL timeout compared=%0d", compared);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_reset_mid;
`ifdef UART_TX_FEED_PARITY_EN
      test_parity;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
